video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Source end of the pixel-counter interface: generates CK_EE_o, HCTRs_o and VCTRs_o for the downstream LED hit judge and font/overlay blocks.
- Also generates the matching active-window, H/V sync and frame-start strobes for the NTSC square-pixel path.
- One frame is progressive: 394 pixel slots per line (0..393) and 263 lines per frame.
- Everything runs on the single system clock; pixel rate is set by a clock-enable divider.

Parameters:
- C_CK_DIV, 4, system clocks per pixel slot (must be >= 2).
- C_H_TOTAL, 394, pixel slots per line.
- C_H_ACT, 320, active pixels per line (0..319).
- C_HS_START, 338, HCTR value where horizontal sync begins.
- C_HS_W, 29, horizontal sync width in pixel slots.
- C_V_TOTAL, 263, lines per frame.
- C_V_ACT, 240, active lines (0..239).
- C_V_SAT, 242, value VCTRs_o holds during vertical blanking.
- C_VS_START, 246, line where vertical sync begins.
- C_VS_N, 3, vertical sync length in lines.

Ports:
- CK_i  in  1  system clock, rising edge.
- ARST_i  in  1  asynchronous reset, active-high.
- EN_i  in  1  run enable; 0 freezes the divider and all counters.
- CK_EE_o  out  1  one-CK pixel strobe, every C_CK_DIV clocks.
- HCTRs_o  out  9  pixel index 0..C_H_TOTAL-1.
- VCTRs_o  out  8  line index 0..C_V_SAT, saturating.
- ACTIVE_o  out  1  HCTR < C_H_ACT and line < C_V_ACT.
- XHSYNC_o  out  1  horizontal sync, active-low.
- XVSYNC_o  out  1  vertical sync, active-low.
- XCSYNC_o  out  1  XHSYNC_o XNOR XVSYNC_o (serrated composite sync), registered.
- FRAME_o  out  1  one-CK pulse coincident with CK_EE_o when HCTR=0 and line=0.

Behaviour:
- Reset (asynchronous, while ARST_i=1):
  - Divider=0, HCTR=0, internal LINE (9-bit)=0.
  - CK_EE_o=0, HCTRs_o=0, VCTRs_o=0, ACTIVE_o=0, FRAME_o=0.
  - XHSYNC_o=1, XVSYNC_o=1, XCSYNC_o=1.
- Divider:
  - Counts 0..C_CK_DIV-1 while EN_i=1.
  - CK_EE_o=1 for exactly the one CK in which the divider equals C_CK_DIV-1. After reset release with EN_i=1, the first pulse occurs in CK cycle C_CK_DIV (1-based).
- Counter advance:
  - On the CK edge that samples CK_EE_o=1, HCTR increments.
  - At C_H_TOTAL-1, HCTR wraps to 0 and LINE increments.
  - At line wrap (LINE=C_V_TOTAL-1 and HCTR wrap), LINE goes to 0.
  - Outputs are therefore stable for the full C_CK_DIV-cycle window around each consumer sampling edge.
- VCTRs_o: LINE[7:0] when LINE <= C_V_SAT, otherwise C_V_SAT. VCTRs_o never wraps through 255.
- ACTIVE_o, XHSYNC_o, XVSYNC_o, FRAME_o:
  - All registered, updated on the same edge as the counters, so they align with HCTRs_o/VCTRs_o (zero relative latency).
  - XHSYNC_o=0 for C_HS_START <= HCTR < C_HS_START+C_HS_W.
  - XVSYNC_o=0 for C_VS_START <= LINE < C_VS_START+C_VS_N.
- FRAME_o: asserted on the single CK where CK_EE_o=1 while HCTRs_o=0 and LINE=0, i.e. the first pixel slot of each frame after its counters are presented.
- XCSYNC_o: one CK later than XHSYNC_o/XVSYNC_o (extra register). This offset is documented and accepted.
- EN_i=0:
  - All state holds and CK_EE_o=0 immediately.
  - On resume, the divider continues from its held value; no counter skip.
- Reset asserted mid-line or mid-sync: all outputs return to reset values asynchronously. On release the frame restarts at HCTR=0, LINE=0. No partial sync pulse is extended.
- Width rules:
  - HCTR is 9-bit. The C_H_TOTAL<=512 check is elaborated.
  - LINE is 9-bit. C_V_TOTAL<=512 and C_V_SAT<=255 are elaborated.

Decomposition:
- The shared define include holds the NTSC square-pixel timing constants (H/V totals, active sizes, sync positions). The LED judge and this block then quote the same active sizes.
- Sub-module ck_ee_gen (parameter C_CK_DIV; ports CK_i, ARST_i, EN_i, CK_EE_o) holds the divider. It is reusable by other pixel-rate blocks.

Test Plan:
- Reset, C_CK_DIV=4, EN_i=1 → CK_EE_o first high in CK cycle 4, then every 4 CKs; HCTRs_o=1 after that edge.
- Run one full line → HCTRs_o sequence 0..393 then 0, with VCTRs_o 0→1 at the wrap; XHSYNC_o low exactly while HCTRs_o in 338..366 (29 slots).
- Run full frame → VCTRs_o climbs 0..242, holds 242 from line 243 through 262, returns to 0. XVSYNC_o is low during lines 246..248. FRAME_o pulses once per 394*263*4 = 414488 CKs.
- ACTIVE_o check → high for HCTRs_o 0..319 on lines 0..239 (76800 slots per frame); low at HCTRs_o=320 and at line 240.
- EN_i held low 10 CKs mid-line at HCTRs_o=100 → no CK_EE_o pulses, HCTRs_o stays 100; the next pulse comes (C_CK_DIV minus elapsed divider count) CKs after EN_i rises.
- ARST_i pulsed while XHSYNC_o=0 at line 150 → immediately XHSYNC_o=1, HCTRs_o=0, VCTRs_o=0; after release the next XHSYNC_o low starts at HCTR 338 of line 0.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// NTSC square-pixel timing constants and pixel-counter types shared by the
// timing generator and its downstream consumers (LED hit judge, overlays).
package video_timing_gen_pkg;

   localparam int unsigned NTSC_CK_DIV    = 4;
   localparam int unsigned NTSC_H_TOTAL   = 394;
   localparam int unsigned NTSC_H_ACT     = 320;
   localparam int unsigned NTSC_HS_START  = 338;
   localparam int unsigned NTSC_HS_W      = 29;
   localparam int unsigned NTSC_V_TOTAL   = 263;
   localparam int unsigned NTSC_V_ACT     = 240;
   localparam int unsigned NTSC_V_SAT     = 242;
   localparam int unsigned NTSC_VS_START  = 246;
   localparam int unsigned NTSC_VS_N      = 3;

   localparam int unsigned HCTR_W = 9;
   localparam int unsigned LINE_W = 9;
   localparam int unsigned VCTR_W = 8;

   typedef logic [HCTR_W-1:0] hctr_t;
   typedef logic [LINE_W-1:0] line_t;
   typedef logic [VCTR_W-1:0] vctr_t;

   // Strobes registered alongside the counters; frame is an internal
   // "next CK_EE is the first slot of a frame" flag, gated by CK_EE on output.
   typedef struct packed {
      logic active;
      logic xhsync;
      logic xvsync;
      logic frame;
   } strobe_t;

   localparam strobe_t STROBE_RST = '{active: 1'b0, xhsync: 1'b1, xvsync: 1'b1, frame: 1'b1};

   function automatic logic in_window(input int unsigned pos,
                                      input int unsigned start,
                                      input int unsigned width);
      return (pos >= start) && (pos < start + width);
   endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel-counter bus from the timing generator to its consumers.
interface video_timing_gen_if;
   import video_timing_gen_pkg::*;

   logic  CK_EE_o;
   hctr_t HCTRs_o;
   vctr_t VCTRs_o;
   logic  ACTIVE_o;
   logic  XHSYNC_o;
   logic  XVSYNC_o;
   logic  XCSYNC_o;
   logic  FRAME_o;

   modport master (
      output CK_EE_o, HCTRs_o, VCTRs_o, ACTIVE_o,
      output XHSYNC_o, XVSYNC_o, XCSYNC_o, FRAME_o
   );

   modport slave (
      input CK_EE_o, HCTRs_o, VCTRs_o, ACTIVE_o,
      input XHSYNC_o, XVSYNC_o, XCSYNC_o, FRAME_o
   );

endinterface

// File: rtl/video_timing_gen_ck_ee_gen.sv
// Pixel-rate clock-enable divider: one-CK strobe every C_CK_DIV system clocks,
// frozen (strobe forced low) while EN_i is low.
module ck_ee_gen #(
   parameter int unsigned C_CK_DIV = 4
) (
   input  logic CK_i,
   input  logic ARST_i,
   input  logic EN_i,
   output logic CK_EE_o
);

   localparam int unsigned DIV_W = $clog2(C_CK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(C_CK_DIV - 1);

   if (C_CK_DIV < 2) begin : g_chk_div
      $error("ck_ee_gen: C_CK_DIV must be at least 2");
   end

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   always_comb begin
      div_d = div_q;
      if (EN_i) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
   end

   always_ff @(posedge CK_i or posedge ARST_i) begin
      if (ARST_i) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign CK_EE_o = EN_i && (div_q == DIV_LAST);

endmodule

// File: rtl/video_timing_gen.sv
// Progressive NTSC timing generator: pixel/line counters plus active window,
// H/V/composite sync and frame-start strobes, all advanced on the pixel strobe.
module video_timing_gen
   import video_timing_gen_pkg::*;
#(
   parameter int unsigned C_CK_DIV   = NTSC_CK_DIV,
   parameter int unsigned C_H_TOTAL  = NTSC_H_TOTAL,
   parameter int unsigned C_H_ACT    = NTSC_H_ACT,
   parameter int unsigned C_HS_START = NTSC_HS_START,
   parameter int unsigned C_HS_W     = NTSC_HS_W,
   parameter int unsigned C_V_TOTAL  = NTSC_V_TOTAL,
   parameter int unsigned C_V_ACT    = NTSC_V_ACT,
   parameter int unsigned C_V_SAT    = NTSC_V_SAT,
   parameter int unsigned C_VS_START = NTSC_VS_START,
   parameter int unsigned C_VS_N     = NTSC_VS_N
) (
   input  logic               CK_i,
   input  logic               ARST_i,
   input  logic               EN_i,
   video_timing_gen_if.master vid_o
);

   if (C_H_TOTAL > 512) begin : g_chk_h_total
      $error("video_timing_gen: C_H_TOTAL exceeds the 9-bit HCTR range");
   end
   if (C_V_TOTAL > 512) begin : g_chk_v_total
      $error("video_timing_gen: C_V_TOTAL exceeds the 9-bit LINE range");
   end
   if (C_V_SAT > 255) begin : g_chk_v_sat
      $error("video_timing_gen: C_V_SAT exceeds the 8-bit VCTR range");
   end

   localparam hctr_t H_LAST = hctr_t'(C_H_TOTAL - 1);
   localparam line_t V_LAST = line_t'(C_V_TOTAL - 1);

   logic    ck_ee;
   hctr_t   hctr_q;
   hctr_t   hctr_d;
   line_t   line_q;
   line_t   line_d;
   strobe_t strobe_q;
   strobe_t strobe_d;
   logic    xcsync_q;
   logic    xcsync_d;
   vctr_t   vctr;

   ck_ee_gen #(
      .C_CK_DIV (C_CK_DIV)
   ) u_ck_ee_gen (
      .CK_i    (CK_i),
      .ARST_i  (ARST_i),
      .EN_i    (EN_i),
      .CK_EE_o (ck_ee)
   );

   // Strobes are derived from the next counter values so they land on the
   // same edge as the counters they describe.
   always_comb begin
      hctr_d   = hctr_q;
      line_d   = line_q;
      strobe_d = strobe_q;
      if (ck_ee) begin
         if (hctr_q == H_LAST) begin
            hctr_d = '0;
            line_d = (line_q == V_LAST) ? '0 : line_q + 1'b1;
         end else begin
            hctr_d = hctr_q + 1'b1;
         end
         strobe_d.active = (32'(hctr_d) < C_H_ACT) && (32'(line_d) < C_V_ACT);
         strobe_d.xhsync = !in_window(32'(hctr_d), C_HS_START, C_HS_W);
         strobe_d.xvsync = !in_window(32'(line_d), C_VS_START, C_VS_N);
         strobe_d.frame  = (hctr_d == '0) && (line_d == '0);
      end
   end

   assign xcsync_d = ~(strobe_q.xhsync ^ strobe_q.xvsync);

   always_ff @(posedge CK_i or posedge ARST_i) begin
      if (ARST_i) begin
         hctr_q   <= '0;
         line_q   <= '0;
         strobe_q <= STROBE_RST;
         xcsync_q <= 1'b1;
      end else begin
         hctr_q   <= hctr_d;
         line_q   <= line_d;
         strobe_q <= strobe_d;
         xcsync_q <= xcsync_d;
      end
   end

   // Blanking lines beyond C_V_SAT all report C_V_SAT so VCTR never wraps.
   assign vctr = (32'(line_q) > C_V_SAT) ? vctr_t'(C_V_SAT) : line_q[VCTR_W-1:0];

   assign vid_o.CK_EE_o  = ck_ee;
   assign vid_o.HCTRs_o  = hctr_q;
   assign vid_o.VCTRs_o  = vctr;
   assign vid_o.ACTIVE_o = strobe_q.active;
   assign vid_o.XHSYNC_o = strobe_q.xhsync;
   assign vid_o.XVSYNC_o = strobe_q.xvsync;
   assign vid_o.XCSYNC_o = xcsync_q;
   assign vid_o.FRAME_o  = strobe_q.frame & ck_ee;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: NTSC-default instance plus a shrunken-timing instance,
// both checked against a closed-form model driven by the enabled-clock count.
module tb_video_timing_gen;

   typedef struct packed {
      int dv; int ht; int hact; int hss; int hsw;
      int vt; int vact; int vsat; int vss; int vsn;
   } timing_t;

   localparam timing_t TA = '{4, 394, 320, 338, 29, 263, 240, 242, 246, 3};
   localparam timing_t TB = '{3, 24, 16, 18, 3, 14, 8, 10, 11, 2};
   // {CK_EE, HCTR, VCTR, ACTIVE, XHSYNC, XVSYNC, XCSYNC, FRAME}
   localparam logic [22:0] RST_VEC = {1'b0, 9'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

   logic ck = 1'b0;
   logic arst = 1'b1;
   logic en = 1'b0;
   int   k = 0;
   int   kp = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 ck = ~ck;

   video_timing_gen_if vid_a ();
   video_timing_gen_if vid_b ();

   video_timing_gen dut_a (
      .CK_i   (ck),
      .ARST_i (arst),
      .EN_i   (en),
      .vid_o  (vid_a)
   );

   video_timing_gen #(
      .C_CK_DIV (3), .C_H_TOTAL (24), .C_H_ACT (16), .C_HS_START (18), .C_HS_W (3),
      .C_V_TOTAL (14), .C_V_ACT (8), .C_V_SAT (10), .C_VS_START (11), .C_VS_N (2)
   ) dut_b (
      .CK_i   (ck),
      .ARST_i (arst),
      .EN_i   (en),
      .vid_o  (vid_b)
   );

   logic [22:0] obs_a;
   logic [22:0] obs_b;
   assign obs_a = {vid_a.CK_EE_o, vid_a.HCTRs_o, vid_a.VCTRs_o, vid_a.ACTIVE_o,
                   vid_a.XHSYNC_o, vid_a.XVSYNC_o, vid_a.XCSYNC_o, vid_a.FRAME_o};
   assign obs_b = {vid_b.CK_EE_o, vid_b.HCTRs_o, vid_b.VCTRs_o, vid_b.ACTIVE_o,
                   vid_b.XHSYNC_o, vid_b.XVSYNC_o, vid_b.XCSYNC_o, vid_b.FRAME_o};

   // Expected outputs after kk enabled clocks since reset; kpp is the count one
   // clock earlier (the composite sync lags by one register).
   function automatic logic [22:0] model(timing_t p, int kk, int kpp, logic e);
      int n, h, ln, np, hp, lp, vc;
      logic ck_x, act, xh, xv, xhp, xvp, fr;
      n    = kk / p.dv;
      h    = n % p.ht;
      ln   = (n / p.ht) % p.vt;
      np   = kpp / p.dv;
      hp   = np % p.ht;
      lp   = (np / p.ht) % p.vt;
      ck_x = e && ((kk % p.dv) == p.dv - 1);
      act  = (n != 0) && (h < p.hact) && (ln < p.vact);
      xh   = !((h >= p.hss) && (h < p.hss + p.hsw));
      xv   = !((ln >= p.vss) && (ln < p.vss + p.vsn));
      xhp  = !((hp >= p.hss) && (hp < p.hss + p.hsw));
      xvp  = !((lp >= p.vss) && (lp < p.vss + p.vsn));
      vc   = (ln > p.vsat) ? p.vsat : ln;
      fr   = ck_x && (h == 0) && (ln == 0);
      return {ck_x, 9'(h), 8'(vc), act, xh, xv, (xhp == xvp), fr};
   endfunction

   task automatic cycle();
      @(posedge ck);
      kp = k;
      if (!arst && en) k++;
      @(negedge ck);
   endtask

   task automatic test_reset();
      arst = 1'b1;
      en   = 1'b1;
      k    = 0;
      kp   = 0;
      repeat (3) begin
         cycle();
         n_checks++;
         if (obs_a !== RST_VEC) begin
            n_fail++; $display("FAIL reset_a: got %h expected %h", obs_a, RST_VEC);
         end
         n_checks++;
         if (obs_b !== RST_VEC) begin
            n_fail++; $display("FAIL reset_b: got %h expected %h", obs_b, RST_VEC);
         end
      end
      arst = 1'b0;
   endtask

   task automatic test_first_pulse();
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) cycle();
         n_checks++;
         if (vid_a.CK_EE_o !== 1'((c % 4) == 0)) begin
            n_fail++; $display("FAIL first_pulse cycle %0d: CK_EE got %b", c, vid_a.CK_EE_o);
         end
         if (c == 5) begin
            n_checks++;
            if (vid_a.HCTRs_o !== 9'd1) begin
               n_fail++; $display("FAIL first_advance: HCTR got %0d expected 1", vid_a.HCTRs_o);
            end
         end
         n_checks += 2;
         if (obs_a !== model(TA, k, kp, en)) begin
            n_fail++; $display("FAIL first_a k=%0d: got %h expected %h", k, obs_a, model(TA, k, kp, en));
         end
         if (obs_b !== model(TB, k, kp, en)) begin
            n_fail++; $display("FAIL first_b k=%0d: got %h expected %h", k, obs_b, model(TB, k, kp, en));
         end
      end
   endtask

   task automatic test_line();
      int steps = 0;
      int low_slots = 0;
      int lo_min = 999;
      int lo_max = -1;
      logic seq_ok = 1'b1;
      logic [8:0] prev_h = vid_a.HCTRs_o;
      while (vid_a.VCTRs_o == 8'd0 && steps < 2000) begin
         cycle();
         steps++;
         n_checks += 2;
         if (obs_a !== model(TA, k, kp, en)) begin
            n_fail++; $display("FAIL line_a k=%0d: got %h expected %h", k, obs_a, model(TA, k, kp, en));
         end
         if (obs_b !== model(TB, k, kp, en)) begin
            n_fail++; $display("FAIL line_b k=%0d: got %h expected %h", k, obs_b, model(TB, k, kp, en));
         end
         if (vid_a.HCTRs_o != prev_h) begin
            if (vid_a.HCTRs_o != ((prev_h == 9'd393) ? 9'd0 : prev_h + 9'd1)) seq_ok = 1'b0;
            prev_h = vid_a.HCTRs_o;
         end
         if (vid_a.CK_EE_o && !vid_a.XHSYNC_o && vid_a.VCTRs_o == 8'd0) begin
            low_slots++;
            if (int'(vid_a.HCTRs_o) < lo_min) lo_min = int'(vid_a.HCTRs_o);
            if (int'(vid_a.HCTRs_o) > lo_max) lo_max = int'(vid_a.HCTRs_o);
         end
      end
      n_checks++;
      if (steps >= 2000) begin
         n_fail++; $display("FAIL line_timeout: no line wrap within %0d CKs", steps);
      end
      n_checks++;
      if (vid_a.HCTRs_o !== 9'd0 || vid_a.VCTRs_o !== 8'd1) begin
         n_fail++; $display("FAIL line_wrap: HCTR %0d VCTR %0d expected 0/1", vid_a.HCTRs_o, vid_a.VCTRs_o);
      end
      n_checks++;
      if (seq_ok !== 1'b1) begin
         n_fail++; $display("FAIL line_sequence: HCTR did not step 0..393 then 0");
      end
      n_checks++;
      if (low_slots != 29 || lo_min != 338 || lo_max != 366) begin
         n_fail++; $display("FAIL hsync_window: %0d slots %0d..%0d expected 29 slots 338..366",
                            low_slots, lo_min, lo_max);
      end
   endtask

   task automatic test_reset_mid_hsync();
      int steps = 0;
      while (vid_a.XHSYNC_o !== 1'b0 && steps < 2000) begin
         cycle();
         steps++;
         n_checks++;
         if (obs_a !== model(TA, k, kp, en)) begin
            n_fail++; $display("FAIL pre_rst_a k=%0d: got %h expected %h", k, obs_a, model(TA, k, kp, en));
         end
      end
      repeat ($urandom_range(0, 40)) cycle();
      n_checks++;
      if (vid_a.XHSYNC_o !== 1'b0 || vid_a.VCTRs_o !== 8'd1) begin
         n_fail++; $display("FAIL pre_rst_state: XHSYNC %b VCTR %0d expected 0/1", vid_a.XHSYNC_o, vid_a.VCTRs_o);
      end
      arst = 1'b1;
      k    = 0;
      kp   = 0;
      #1;
      n_checks++;
      if (vid_a.XHSYNC_o !== 1'b1 || vid_a.HCTRs_o !== 9'd0 || vid_a.VCTRs_o !== 8'd0) begin
         n_fail++; $display("FAIL async_rst: XHSYNC %b HCTR %0d VCTR %0d expected 1/0/0",
                            vid_a.XHSYNC_o, vid_a.HCTRs_o, vid_a.VCTRs_o);
      end
      n_checks += 2;
      if (obs_a !== RST_VEC) begin
         n_fail++; $display("FAIL async_rst_a: got %h expected %h", obs_a, RST_VEC);
      end
      if (obs_b !== RST_VEC) begin
         n_fail++; $display("FAIL async_rst_b: got %h expected %h", obs_b, RST_VEC);
      end
      cycle();
      cycle();
      arst  = 1'b0;
      steps = 0;
      while (vid_a.XHSYNC_o !== 1'b0 && steps < 2000) begin
         cycle();
         steps++;
         n_checks += 2;
         if (obs_a !== model(TA, k, kp, en)) begin
            n_fail++; $display("FAIL post_rst_a k=%0d: got %h expected %h", k, obs_a, model(TA, k, kp, en));
         end
         if (obs_b !== model(TB, k, kp, en)) begin
            n_fail++; $display("FAIL post_rst_b k=%0d: got %h expected %h", k, obs_b, model(TB, k, kp, en));
         end
      end
      n_checks++;
      if (steps >= 2000 || vid_a.HCTRs_o !== 9'd338 || vid_a.VCTRs_o !== 8'd0) begin
         n_fail++; $display("FAIL post_rst_hsync: HCTR %0d VCTR %0d expected 338/0",
                            vid_a.HCTRs_o, vid_a.VCTRs_o);
      end
   endtask

   task automatic test_en_freeze();
      int steps = 0;
      int r;
      int w = 0;
      while (vid_a.HCTRs_o !== 9'd100 && steps < 3000) begin
         cycle();
         steps++;
         n_checks++;
         if (obs_a !== model(TA, k, kp, en)) begin
            n_fail++; $display("FAIL pre_freeze_a k=%0d: got %h expected %h", k, obs_a, model(TA, k, kp, en));
         end
      end
      n_checks++;
      if (steps >= 3000) begin
         n_fail++; $display("FAIL freeze_timeout: HCTR never reached 100");
      end
      r = $urandom_range(0, 3);
      repeat (r) cycle();
      en = 1'b0;
      #1;
      n_checks++;
      if (vid_a.CK_EE_o !== 1'b0) begin
         n_fail++; $display("FAIL freeze_immediate: CK_EE got %b expected 0", vid_a.CK_EE_o);
      end
      repeat (10) begin
         cycle();
         n_checks++;
         if (vid_a.CK_EE_o !== 1'b0 || vid_a.HCTRs_o !== 9'd100) begin
            n_fail++; $display("FAIL freeze_hold: CK_EE %b HCTR %0d expected 0/100", vid_a.CK_EE_o, vid_a.HCTRs_o);
         end
         n_checks += 2;
         if (obs_a !== model(TA, k, kp, en)) begin
            n_fail++; $display("FAIL freeze_a k=%0d: got %h expected %h", k, obs_a, model(TA, k, kp, en));
         end
         if (obs_b !== model(TB, k, kp, en)) begin
            n_fail++; $display("FAIL freeze_b k=%0d: got %h expected %h", k, obs_b, model(TB, k, kp, en));
         end
      end
      en = 1'b1;
      #1;
      while (vid_a.CK_EE_o !== 1'b1 && w < 10) begin
         cycle();
         w++;
      end
      n_checks++;
      if (w != 3 - r || vid_a.HCTRs_o !== 9'd100) begin
         n_fail++; $display("FAIL resume: pulse after %0d CKs at HCTR %0d expected %0d CKs at 100",
                            w, vid_a.HCTRs_o, 3 - r);
      end
      cycle();
      n_checks++;
      if (vid_a.HCTRs_o !== 9'd101) begin
         n_fail++; $display("FAIL resume_step: HCTR got %0d expected 101", vid_a.HCTRs_o);
      end
   endtask

   task automatic test_frame_b();
      int frames_a = 0;
      int frames_b = 0;
      int act_b = 0;
      int vs_b = 0;
      int sat_b = 0;
      int vmax_b = 0;
      int fk0 = -1;
      int fk1 = -1;
      arst = 1'b1;
      en   = 1'b1;
      k    = 0;
      kp   = 0;
      cycle();
      arst = 1'b0;
      for (int i = 0; i < 3 * 24 * 14 * 3; i++) begin
         cycle();
         n_checks += 2;
         if (obs_a !== model(TA, k, kp, en)) begin
            n_fail++; $display("FAIL frame_a k=%0d: got %h expected %h", k, obs_a, model(TA, k, kp, en));
         end
         if (obs_b !== model(TB, k, kp, en)) begin
            n_fail++; $display("FAIL frame_b k=%0d: got %h expected %h", k, obs_b, model(TB, k, kp, en));
         end
         if (vid_a.FRAME_o) frames_a++;
         if (vid_b.FRAME_o) begin
            frames_b++;
            if (fk0 < 0) fk0 = k; else if (fk1 < 0) fk1 = k;
         end
         if (int'(vid_b.VCTRs_o) > vmax_b) vmax_b = int'(vid_b.VCTRs_o);
         if (vid_b.CK_EE_o) begin
            if (vid_b.ACTIVE_o) act_b++;
            if (!vid_b.XVSYNC_o) vs_b++;
            if (vid_b.VCTRs_o == 8'd10) sat_b++;
         end
      end
      n_checks++;
      if (frames_b != 3 || fk1 - fk0 != 1008) begin
         n_fail++; $display("FAIL frame_pulses_b: %0d pulses period %0d expected 3 period 1008",
                            frames_b, fk1 - fk0);
      end
      n_checks++;
      if (frames_a != 1) begin
         n_fail++; $display("FAIL frame_pulses_a: %0d pulses expected 1", frames_a);
      end
      n_checks++;
      if (act_b != 3 * 16 * 8 - 1) begin
         n_fail++; $display("FAIL active_slots_b: %0d expected %0d", act_b, 3 * 16 * 8 - 1);
      end
      n_checks++;
      if (vs_b != 3 * 2 * 24) begin
         n_fail++; $display("FAIL vsync_slots_b: %0d expected %0d", vs_b, 3 * 2 * 24);
      end
      n_checks++;
      if (sat_b != 3 * 4 * 24 || vmax_b != 10) begin
         n_fail++; $display("FAIL vctr_sat_b: %0d slots max %0d expected %0d slots max 10",
                            sat_b, vmax_b, 3 * 4 * 24);
      end
   endtask

   task automatic test_random_en();
      for (int i = 0; i < 4000; i++) begin
         en = ($urandom_range(0, 3) != 0);
         if (arst) begin
            arst = 1'b0;
         end else if ($urandom_range(0, 1499) == 0) begin
            arst = 1'b1;
            k    = 0;
            kp   = 0;
         end
         cycle();
         n_checks += 2;
         if (obs_a !== model(TA, k, kp, en)) begin
            n_fail++; $display("FAIL random_a k=%0d: got %h expected %h", k, obs_a, model(TA, k, kp, en));
         end
         if (obs_b !== model(TB, k, kp, en)) begin
            n_fail++; $display("FAIL random_b k=%0d: got %h expected %h", k, obs_b, model(TB, k, kp, en));
         end
      end
      arst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_pulse();
      test_line();
      test_reset_mid_hsync();
      test_en_freeze();
      test_frame_b();
      test_random_en();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
